// File: rtl/fifo_stream_pkg.sv
// Shared types and sizing helpers for the FIFO-to-byte-stream read engine.
package fifo_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int bytes_of(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int idx_width(input int data_width);
    return (data_width / 8 > 1) ? $clog2(data_width / 8) : 1;
  endfunction

  localparam int pDATA_WIDTH_DEF = 32;
  localparam int pBYTES          = bytes_of(pDATA_WIDTH_DEF);
  localparam int pIDX_WIDTH      = idx_width(pDATA_WIDTH_DEF);

endpackage

// File: rtl/fifo_stream_reader.sv
// Drains a registered-output FIFO and serializes each word LSB byte first onto
// a valid/ready byte stream, one programmed burst of words per start pulse.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int pDATA_WIDTH  = 32,
  parameter int pBURST_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    srst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [pBURST_WIDTH-1:0] burst_len,
  input  logic                    fifo_empty,
  output logic                    fifo_ren,
  input  logic [pDATA_WIDTH-1:0]  fifo_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic                    stalled
);

  localparam int BYTES = bytes_of(pDATA_WIDTH);
  localparam int IDX_W = idx_width(pDATA_WIDTH);
  localparam int CNT_W = pBURST_WIDTH + IDX_W;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES - 1);

  state_t state, state_nxt;

  logic [pBURST_WIDTH-1:0] fetch_left;
  logic [CNT_W-1:0]        bytes_left;
  logic [pDATA_WIDTH-1:0]  sh_data;
  logic [pDATA_WIDTH-1:0]  buf_data;
  logic [IDX_W-1:0]        sh_idx;
  logic                    sh_valid;
  logic                    buf_valid;
  logic                    pend;

  logic       run;
  logic       accept;
  logic       word_done;
  logic       sh_keep;
  logic       slot_free;
  logic [1:0] occ;

  // occ counts words held after this edge; a new read needs a slot when it lands.
  always_comb begin
    run       = (state == RUN);
    accept    = sh_valid && out_ready;
    word_done = accept && (sh_idx == IDX_LAST);
    sh_keep   = sh_valid && !word_done;
    occ       = 2'(sh_keep) + 2'(buf_valid) + 2'(pend);
    slot_free = (occ < 2'd2);
    fifo_ren  = run && (fetch_left != '0) && !fifo_empty && !abort && slot_free;
  end

  always_comb begin
    out_valid = sh_valid;
    out_data  = sh_data[7:0];
    out_last  = (bytes_left == CNT_W'(1));
    busy      = (state != IDLE);
    done      = (state == DONE);
    stalled   = run && out_ready && !sh_valid;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !abort) state_nxt = (burst_len == '0) ? DONE : RUN;
      RUN:  if (abort || (accept && out_last)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      fetch_left <= '0;
      bytes_left <= '0;
      sh_data    <= '0;
      buf_data   <= '0;
      sh_idx     <= '0;
      sh_valid   <= 1'b0;
      buf_valid  <= 1'b0;
      pend       <= 1'b0;
    end else if (state == IDLE && start && !abort) begin
      fetch_left <= burst_len;
      bytes_left <= CNT_W'(burst_len) * CNT_W'(BYTES);
      sh_data    <= '0;
      sh_idx     <= '0;
      sh_valid   <= 1'b0;
      buf_valid  <= 1'b0;
      pend       <= 1'b0;
    end else if (!run || abort) begin
      // Any word still in flight on an abort is dropped when it lands.
      fetch_left <= '0;
      bytes_left <= '0;
      sh_data    <= '0;
      sh_idx     <= '0;
      sh_valid   <= 1'b0;
      buf_valid  <= 1'b0;
      pend       <= 1'b0;
    end else begin
      pend <= fifo_ren;
      if (fifo_ren) fetch_left <= fetch_left - pBURST_WIDTH'(1);
      if (accept)   bytes_left <= bytes_left - CNT_W'(1);

      if (pend && (!sh_valid || word_done)) begin
        sh_data  <= fifo_rdata;
        sh_idx   <= '0;
        sh_valid <= 1'b1;
      end else if (word_done && buf_valid) begin
        sh_data   <= buf_data;
        sh_idx    <= '0;
        sh_valid  <= 1'b1;
        buf_valid <= 1'b0;
      end else if (word_done) begin
        sh_data  <= '0;
        sh_idx   <= '0;
        sh_valid <= 1'b0;
      end else if (accept) begin
        sh_data <= sh_data >> 8;
        sh_idx  <= sh_idx + IDX_W'(1);
      end

      if (pend && sh_keep) begin
        buf_data  <= fifo_rdata;
        buf_valid <= 1'b1;
      end
    end
  end

endmodule
